// File: rtl/audio_mix_pkg.sv
// Shared types and constants for the offline two-track SRAM mixer.
package audio_mix_pkg;

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        RD_A,
        RD_B,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        NEXT,
        DONE
    } mix_state_t;

    localparam int DEFAULT_TRACK_LEN    = 128000;
    localparam int DEFAULT_TRACK_A_BASE = 0;
    localparam int DEFAULT_TRACK_B_BASE = 128000;

    localparam int SAMPLE_MAX = 32767;
    localparam int SAMPLE_MIN = -32768;

endpackage

// File: rtl/mix_alu.sv
// Combinational sample combiner: average by default, clamped full-scale sum
// when MIX_SATURATE_EN is defined.
module mix_alu
    import audio_mix_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] mix
);

    logic signed [DATA_W:0] sum;

    always_comb begin
        sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
`ifdef MIX_SATURATE_EN
        if (sum > (DATA_W+1)'(SAMPLE_MAX)) begin
            mix = DATA_W'(SAMPLE_MAX);
        end else if (sum < (DATA_W+1)'(SAMPLE_MIN)) begin
            mix = DATA_W'(SAMPLE_MIN);
        end else begin
            mix = sum[DATA_W-1:0];
        end
`else
        // Arithmetic shift keeps the sign, so odd negative sums round toward -inf.
        mix = DATA_W'(sum >>> 1);
`endif
    end

endmodule

// File: rtl/track_mix_engine.sv
// Offline mixer: A[i] <= mix(A[i], B[i]) over the shared SRAM while granted.
// Mix function selected by MIX_SATURATE_EN inside mix_alu.
module track_mix_engine
    import audio_mix_pkg::*;
#(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16,
    parameter int TRACK_LEN    = DEFAULT_TRACK_LEN,
    parameter int TRACK_A_BASE = DEFAULT_TRACK_A_BASE,
    parameter int TRACK_B_BASE = DEFAULT_TRACK_B_BASE,
    parameter int RD_WAIT      = 1
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iStart,
    input  logic              iAbort,
    output logic              oReq,
    input  logic              iGnt,
    output logic [ADDR_W-1:0] oSRAM_ADDR,
    input  logic [DATA_W-1:0] iSRAM_RDATA,
    output logic [DATA_W-1:0] oSRAM_WDATA,
    output logic              oSRAM_DQ_OE,
    output logic              oSRAM_WE_N,
    output logic              oSRAM_OE_N,
    output logic              oBusy,
    output logic              oDone,
    output logic [ADDR_W-1:0] oCount,
    inout  wire  [DATA_W-1:0] SRAM_DQ
);

    localparam logic [ADDR_W-1:0] A_BASE    = ADDR_W'(TRACK_A_BASE);
    localparam logic [ADDR_W-1:0] B_BASE    = ADDR_W'(TRACK_B_BASE);
    localparam logic [ADDR_W-1:0] LEN       = ADDR_W'(TRACK_LEN);
    localparam logic [2:0]        WAIT_LAST = 3'(RD_WAIT);

    mix_state_t        state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        wait_q, wait_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] mix;

    // b is never stored: it feeds the ALU straight from the pins on its latch edge.
    mix_alu #(.DATA_W(DATA_W)) u_mix_alu (
        .a   (a_q),
        .b   (iSRAM_RDATA),
        .mix (mix)
    );

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            count_q <= '0;
            addr_q  <= '0;
            wait_q  <= '0;
            a_q     <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            a_q     <= a_d;
            wdata_q <= wdata_d;
        end
    end

    // NOTE: every target gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        wait_d  = wait_q;
        a_d     = a_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (iStart) begin
                    state_d = REQ;
                    count_d = '0;
                end
            end
            REQ: begin
                if (iGnt) begin
                    state_d = RD_A;
                    addr_d  = A_BASE + count_q;
                end
            end
            RD_A: begin
                if (wait_q == WAIT_LAST) begin
                    a_d     = iSRAM_RDATA;
                    wait_d  = '0;
                    state_d = RD_B;
                    addr_d  = B_BASE + count_q;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            RD_B: begin
                if (wait_q == WAIT_LAST) begin
                    wdata_d = mix;
                    wait_d  = '0;
                    state_d = WR_SETUP;
                    addr_d  = A_BASE + count_q;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: state_d = WR_HOLD;
            WR_HOLD:  state_d = NEXT;
            NEXT: begin
                // Grant and abort are only honoured here, between whole samples.
                count_d = count_q + 1'b1;
                if (count_d == LEN || iAbort) begin
                    state_d = DONE;
                end else if (!iGnt) begin
                    state_d = REQ;
                end else begin
                    state_d = RD_A;
                    addr_d  = A_BASE + count_d;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from the state register so reset forces them inactive at once.
    assign oReq        = (state_q != IDLE) && (state_q != DONE);
    assign oSRAM_OE_N  = !((state_q == RD_A) || (state_q == RD_B));
    assign oSRAM_DQ_OE = (state_q == WR_SETUP) || (state_q == WR_PULSE) || (state_q == WR_HOLD);
    assign oSRAM_WE_N  = (state_q != WR_PULSE);
    assign oBusy       = (state_q != IDLE);
    assign oDone       = (state_q == DONE);
    assign oSRAM_ADDR  = addr_q;
    assign oSRAM_WDATA = wdata_q;
    assign oCount      = count_q;

    assign SRAM_DQ = oSRAM_DQ_OE ? oSRAM_WDATA : 'z;

endmodule
